// File: rtl/reg_file_decoded.sv
// Parametrised register file with a one-hot write decoder, two combinational
// read ports, optional write bypass / zero register, dirty mask and write strobe.
module reg_file_decoded #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic                  clr_dirty,
  output logic [DATA_WIDTH-1:0] rd_data0,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [NUM_REGS-1:0]   wr_onehot,
  output logic [NUM_REGS-1:0]   dirty
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   sel;
  logic                  sel_any;

  // Out-of-range addresses never match any decoder output, so they drop out naturally.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we && (wr_addr == ADDR_WIDTH'(i)) && !(ZERO_REG != 0 && i == 0)) begin
        sel[i] = 1'b1;
      end
    end
  end

  assign sel_any = |sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_onehot <= '0;
      dirty     <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sel[i]) begin
          regs[i] <= wr_data;
        end
      end
      wr_onehot <= sel;
      dirty     <= (clr_dirty ? '0 : dirty) | sel;
    end
  end

  always_comb begin
    rd_data0 = '0;
    rd_data1 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        if (rd_addr0 == ADDR_WIDTH'(i)) rd_data0 = regs[i];
        if (rd_addr1 == ADDR_WIDTH'(i)) rd_data1 = regs[i];
      end
    end
    // sel_any already excludes ignored writes, so bypass only forwards accepted data.
    if (BYPASS != 0 && sel_any) begin
      if (rd_addr0 == wr_addr) rd_data0 = wr_data;
      if (rd_addr1 == wr_addr) rd_data1 = wr_data;
    end
  end

endmodule

// File: doc/reg_file_decoded.md
Name: reg_file_decoded

Overview:
Parametrised multi-port register file, successor to the fixed 3-to-8 write-select decoder used in the register_file subsystem. An internal parametrised N-way one-hot write decoder drives a bank of NUM_REGS registers. Two asynchronous read ports are provided, with optional write-to-read bypass and an optional hard-wired zero register. The block also keeps a per-register dirty mask and a registered one-hot write strobe for status and debug.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
ADDR_WIDTH, 3, width of every address port
NUM_REGS, 8, number of implemented registers; legal range 2 to 2**ADDR_WIDTH
ZERO_REG, 0, when 1, register 0 always reads 0 and ignores writes
BYPASS, 1, when 1, a read of the address being written in the same cycle returns wr_data

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
we  input  1  write enable
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
rd_addr0  input  ADDR_WIDTH  read port 0 address
rd_addr1  input  ADDR_WIDTH  read port 1 address
clr_dirty  input  1  clears the dirty mask
rd_data0  output  DATA_WIDTH  read port 0 data (combinational)
rd_data1  output  DATA_WIDTH  read port 1 data (combinational)
wr_onehot  output  NUM_REGS  registered one-hot of the last accepted write
dirty  output  NUM_REGS  per-register "written since clear" mask

Behaviour:
- Reset (reset=1 at a rising edge):
  - all registers, wr_onehot and dirty go to 0
  - reset overrides we and clr_dirty in the same cycle
  - reset asserted mid-sequence discards that cycle's write
- Write decode:
  - sel = one-hot of wr_addr, gated by we
  - sel is all-zero when wr_addr >= NUM_REGS
  - sel is all-zero when ZERO_REG=1 and wr_addr=0
- Write: register[wr_addr] <= wr_data at the rising edge when sel is nonzero. Write latency is 1 cycle.
- Read (combinational, zero latency):
  - rd_dataN = register[rd_addrN]
  - rd_dataN = 0 when rd_addrN >= NUM_REGS, or when ZERO_REG=1 and rd_addrN=0
- Bypass: if BYPASS=1, we=1, and rd_addrN equals wr_addr of an accepted write (sel nonzero), rd_dataN = wr_data in that same cycle. If BYPASS=0, the old value is returned until the next cycle.
- Both read ports may address the same register; each returns identical data independently.
- wr_onehot:
  - next value is sel
  - exactly one bit is high for one cycle after an accepted write, otherwise 0
  - an ignored write (out of range, or register 0 with ZERO_REG=1) yields 0
- dirty:
  - next value is (clr_dirty ? 0 : dirty) | sel
  - when a write and clr_dirty occur together, the written bit stays set
  - rewriting an already-dirty register leaves its bit set
- No state machine beyond the registers. Back-to-back writes every cycle are legal; the last write to an address wins.

Test Plan:
- Reset then read: reset=1 for one cycle; read all addresses 0..7 -> rd_data0 = rd_data1 = 0, wr_onehot = 8'h00, dirty = 8'h00.
- Write/readback: write 3 <- 32'hDEADBEEF, then write 7 <- 32'h12345678; read 3 on port 0 and 7 on port 1 -> 32'hDEADBEEF and 32'h12345678. wr_onehot shows 8'h08, then 8'h80 on successive cycles; dirty = 8'h88.
- Bypass: same-cycle write 5 <- 32'hA5A5A5A5 with rd_addr0=5 -> rd_data0 = 32'hA5A5A5A5 in that cycle with BYPASS=1. With BYPASS=0, the old value (0) is returned in that cycle and 32'hA5A5A5A5 in the next.
- Zero register and range: ZERO_REG=1, write 0 <- 32'hFFFFFFFF -> rd 0 = 0, wr_onehot = 0, dirty bit 0 stays 0. NUM_REGS=6, ADDR_WIDTH=3, write 6 <- 32'h1 -> ignored; rd 6 = 0.
- Dirty clear race: dirty = 8'h88; in one cycle assert clr_dirty=1 with a write to 2 -> next cycle dirty = 8'h04.
- Reset mid-operation: we=1, wr_addr=4, wr_data=32'h55 with reset=1 in the same cycle -> register 4 = 0, dirty = 0 next cycle. A write to 4 on the following cycle succeeds.
